// File: rtl/alu_issue_ctrl.sv
// Issue controller that decodes one instruction, drives a registered external ALU,
// and returns the captured result through a ready/valid response port.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] alu_srca,
  output logic [31:0] alu_srcb,
  output logic [3:0]  alu_af,
  output logic        alu_i,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [2:0]  res_flags,
  output logic [4:0]  res_rd,
  output logic        res_illegal,
  output logic [15:0] retired_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] srca_q;
  logic [31:0] srcb_q;
  logic [3:0]  af_q;
  logic        i_q;
  logic [31:0] data_q;
  logic [2:0]  flags_q;
  logic [4:0]  rd_q;
  logic        illegal_q;
  logic [15:0] cnt_q;

  logic        itype;
  logic [3:0]  op;
  logic        legal_d;
  logic [3:0]  af_d;
  logic        i_d;
  logic [31:0] srcb_d;
  logic        unused_bits;

  assign itype       = instr[31];
  assign op          = instr[30:27];
  assign unused_bits = ^instr[21:16];

  // R-type ops 0..6 use the upper half of the function space; I-type ops 0..7 the lower.
  always_comb begin
    legal_d = 1'b0;
    af_d    = 4'b0000;
    i_d     = 1'b0;
    srcb_d  = opb;
    if (itype) begin
      legal_d = ~op[3];
      af_d    = {1'b0, op[2:0]};
      i_d     = 1'b1;
      srcb_d  = {{16{instr[15]}}, instr[15:0]};
    end else begin
      legal_d = ~op[3] & (op[2:0] != 3'b111);
      af_d    = {1'b1, op[2:0]};
      i_d     = 1'b0;
      srcb_d  = opb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      srca_q    <= '0;
      srcb_q    <= '0;
      af_q      <= '0;
      i_q       <= 1'b0;
      data_q    <= '0;
      flags_q   <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            rd_q    <= instr[26:22];
            ready_q <= 1'b0;
            if (legal_d) begin
              srca_q  <= opa;
              srcb_q  <= srcb_d;
              af_q    <= af_d;
              i_q     <= i_d;
              state_q <= EXEC;
            end else begin
              // Illegal instructions skip the ALU and leave its operands untouched.
              illegal_q <= 1'b1;
              data_q    <= '0;
              flags_q   <= '0;
              valid_q   <= 1'b1;
              state_q   <= RESP;
            end
          end
        end
        EXEC: begin
          data_q    <= alu_res;
          flags_q   <= {alu_ovf, alu_neg, alu_zero};
          illegal_q <= 1'b0;
          valid_q   <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
            if (!illegal_q && (cnt_q != 16'hFFFF)) begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign res_valid   = valid_q;
  assign alu_srca    = srca_q;
  assign alu_srcb    = srcb_q;
  assign alu_af      = af_q;
  assign alu_i       = i_q;
  assign res_data    = data_q;
  assign res_flags   = flags_q;
  assign res_rd      = rd_q;
  assign res_illegal = illegal_q;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port instr_valid, input, 1 bit: instruction offered.
REQ-004 SHALL have port instr_ready, output, 1 bit: block accepts an instruction this cycle.
REQ-005 SHALL have port instr, input, 32 bits, with these fields:
- [31] itype.
- [30:27] op.
- [26:22] rd.
- [15:0] imm.
REQ-006 SHALL have ports opa and opb, input, 32 bits each: operand values, sampled with instr.
REQ-007 SHALL have ports alu_srca and alu_srcb, output, 32 bits each: registered ALU operands.
REQ-008 SHALL have ports alu_af, output, 4 bits, and alu_i, output, 1 bit: registered ALU function code and immediate flag.
REQ-009 SHALL have ports alu_res, input, 32 bits, and alu_zero, alu_neg, alu_ovf, input, 1 bit each: combinational ALU result and flags.
REQ-010 SHALL have port res_valid, output, 1 bit, and res_ready, input, 1 bit: result handshake.
REQ-011 SHALL have these result outputs:
- res_data, 32 bits.
- res_flags, 3 bits, {ovf, neg, zero}.
- res_rd, 5 bits.
- res_illegal, 1 bit.
REQ-012 SHALL have port retired_cnt, output, 16 bits: count of legal results delivered.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 instr_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 Acceptance SHALL occur on an edge where instr_valid=1 and instr_ready=1; at that edge instr, opa, opb are captured.
REQ-016 R-type (itype=0) op 0..6 SHALL decode as follows, with alu_i=0 and alu_srcb=opb:
- op 0 AND -> af 1000.
- op 1 OR -> af 1001.
- op 2 ADD -> af 1010.
- op 3 SUB -> af 1011.
- op 4 SLT -> af 1100.
- op 5 SLL -> af 1101.
- op 6 SRL -> af 1110.
REQ-017 I-type (itype=1) op 0..7 SHALL map to af = {1'b0, op[2:0]}, with alu_i=1 and alu_srcb = imm sign-extended to 32 bits.
REQ-018 The following SHALL be illegal:
- R-type op 7..15.
- I-type op 8..15.
REQ-019 On acceptance of a legal instruction: alu_srca=opa, alu_srcb, alu_af and alu_i SHALL load at the same edge, and the state SHALL go IDLE->EXEC.
REQ-020 EXEC SHALL last exactly one cycle. At its ending edge:
- res_data <= alu_res.
- res_flags <= {alu_ovf, alu_neg, alu_zero}.
- res_illegal <= 0.
- state -> RESP.
REQ-021 On acceptance of an illegal instruction, the block SHALL go IDLE->RESP directly and set:
- res_illegal=1.
- res_data=0.
- res_flags=000.
- alu_* outputs unchanged.
REQ-022 res_rd SHALL be loaded from instr[26:22] at acceptance for both legal and illegal instructions.
REQ-023 res_valid SHALL be 1 exactly when the state is RESP.
REQ-024 While res_valid=1 and res_ready=0, all res_* outputs SHALL hold stable.
REQ-025 On an edge with res_valid=1 and res_ready=1, the state SHALL go RESP->IDLE.
REQ-026 An instruction SHALL NOT be accepted in the same cycle as a result handshake; throughput is one instruction per 3 cycles minimum (2 for illegal).
REQ-027 Latency SHALL be:
- Legal: res_valid high in the 2nd cycle after the accepting edge.
- Illegal: res_valid high in the 1st cycle after the accepting edge.
REQ-028 res_ready=1 outside RESP SHALL have no effect.
REQ-029 retired_cnt SHALL increment by 1 on each result handshake with res_illegal=0, and saturate at 0xFFFF.
REQ-030 alu_* outputs SHALL hold their last values in IDLE and RESP.
REQ-031 Unused instr bits [21:16] SHALL be ignored.

Reset
REQ-032 When rst_n=0, immediately and independent of clk, the block SHALL set:
- state IDLE.
- res_valid=0.
- all res_*=0.
- alu_srca, alu_srcb=0.
- alu_af=0000, alu_i=0.
- retired_cnt=0.
REQ-033 Because the block enters IDLE during reset, instr_ready SHALL be 1 while rst_n=0.
REQ-034 Reset asserted in EXEC or RESP SHALL discard the in-flight instruction; no result is delivered and retired_cnt is not incremented.
REQ-035 After rst_n deasserts, the first rising edge SHALL be able to accept an instruction.

Verification
REQ-036 R-type ADD (op 2), opa=5, opb=7, rd=3 -> alu_af=1010, alu_i=0; res_valid 2 cycles later with res_data=12, res_flags=000, res_rd=3; retired_cnt=1 after handshake.
REQ-037 R-type SUB (op 3), opa=opb=0x1234 -> res_data=0, res_flags=001.
REQ-038 I-type op 0, opa=1, imm=0xFFFF -> alu_srcb=0xFFFFFFFF, alu_i=1, alu_af=0000; res_data=0, zero=1.
REQ-039 R-type op 9 -> res_valid 1 cycle after acceptance with res_illegal=1, res_data=0; alu_af unchanged; retired_cnt unchanged after handshake.
REQ-040 Legal instruction with res_ready held 0 for 5 cycles -> res_valid and res_* stable throughout, instr_ready=0 throughout; handshake on the 6th cycle -> IDLE.
REQ-041 rst_n pulsed low during EXEC -> outputs zero immediately, no res_valid afterwards, retired_cnt=0; a new instruction is accepted on the first edge after release.
